// File: rtl/seg7_scan_ctrl_if.sv
// Address and write-strobe lines of the display controller's 8-byte register window.
// Purely combinational wiring; data moves on the separately connected tristate BUS_DATA.
interface seg7_scan_ctrl_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;

    modport master (output BUS_ADDR, output BUS_WE);
    modport slave  (input  BUS_ADDR, input  BUS_WE);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with bus-mapped shadow/active registers, PWM dimming and LZS.
// Pins are registered one clk after scan state; bus reads are combinational, writes never stall.
module seg7_scan_ctrl #(
    parameter logic [7:0] BASE_ADDR   = 8'hD0,
    parameter int         NUM_DIGITS  = 4,
    parameter int         REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seg7_scan_ctrl_if.slave       bus,
    inout  wire  [7:0]            BUS_DATA,
    output logic [NUM_DIGITS-1:0] SEG_SELECT_OUT,
    output logic [7:0]            HEX_OUT
);
    localparam int                SLOT_W    = $clog2(REFRESH_DIV);
    localparam logic [7:0]        MASK8     = 8'((16'd1 << NUM_DIGITS) - 16'd1);
    localparam logic [31:0]       DMASK     = 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [31:0]           dig_sh_q, dig_q;
    logic [7:0]            dp_sh_q, dp_q, blank_sh_q, blank_q, ctrl_sh_q;
    logic [5:0]            ctrl_q;     // {brightness, lzs, enable}
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [2:0]            idx_q, idx_d;
    logic [3:0]            pwm_q;
    logic                  frame_q, frame_d, commit;
    logic [NUM_DIGITS-1:0] seg_q, seg_d;
    logic [7:0]            hex_q, hex_d;

    logic [8:0] addr_off;
    logic [2:0] off;
    logic       hit, wr_en;
    logic [7:0] rdata;

    // 9-bit difference so addresses below BASE_ADDR land far outside the window.
    assign addr_off = {1'b0, bus.BUS_ADDR} - {1'b0, BASE_ADDR};
    assign hit      = addr_off < 9'd8;
    assign off      = addr_off[2:0];
    assign wr_en    = hit && bus.BUS_WE && (off != 3'd7);

    always_comb begin
        rdata = 8'h00;
        case (off)
            3'd4:    rdata = dp_sh_q;
            3'd5:    rdata = blank_sh_q;
            3'd6:    rdata = ctrl_sh_q;
            3'd7:    rdata = {frame_q, 4'b0000, idx_q};
            default: rdata = dig_sh_q[{off[1:0], 3'b000} +: 8];
        endcase
    end

    assign BUS_DATA = (hit && !bus.BUS_WE) ? rdata : 8'hzz;

    always_comb begin
        slot_d  = slot_q + SLOT_W'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        commit  = 1'b0;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d   = 3'd0;
                frame_d = ~frame_q;
                commit  = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    logic [3:0] nib;
    logic [6:0] glyph;
    logic       sup, dp_bit, show;

    always_comb begin
        nib    = dig_q[{idx_q, 2'b00} +: 4];
        dp_bit = dp_q[idx_q];
        // Unused upper nibbles are held at zero, so one shift tests "this digit and all above are 0".
        sup    = ctrl_q[1] && (idx_q != 3'd0) && ((dig_q >> {idx_q, 2'b00}) == 32'd0);
        show   = ctrl_q[0] && (slot_q != '0) && (pwm_q <= ctrl_q[5:2])
                 && !blank_q[idx_q] && (!sup || dp_bit);
        case (nib)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
        seg_d = '1;
        hex_d = 8'hFF;
        if (show) begin
            seg_d = ~(NUM_DIGITS'(1) << idx_q);
            hex_d = {~dp_bit, sup ? 7'h7F : glyph};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= '0;
            idx_q   <= 3'd0;
            pwm_q   <= 4'd0;
            frame_q <= 1'b0;
            seg_q   <= '1;
            hex_q   <= 8'hFF;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            pwm_q   <= pwm_q + 4'd1;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            hex_q   <= hex_d;
        end
    end

    // Commit samples shadow before any same-edge write lands, so that write waits a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_sh_q   <= 32'd0;
            dp_sh_q    <= 8'h00;
            blank_sh_q <= 8'h00;
            ctrl_sh_q  <= 8'hF1;
            dig_q      <= 32'd0;
            dp_q       <= 8'h00;
            blank_q    <= 8'h00;
            ctrl_q     <= 6'b1111_01;
        end else begin
            if (commit) begin
                dig_q   <= dig_sh_q;
                dp_q    <= dp_sh_q;
                blank_q <= blank_sh_q;
                ctrl_q  <= {ctrl_sh_q[7:4], ctrl_sh_q[1:0]};
            end
            if (wr_en) begin
                case (off)
                    3'd4:    dp_sh_q    <= BUS_DATA & MASK8;
                    3'd5:    blank_sh_q <= BUS_DATA & MASK8;
                    3'd6:    ctrl_sh_q  <= BUS_DATA;
                    default: dig_sh_q[{off[1:0], 3'b000} +: 8] <=
                                 BUS_DATA & DMASK[{off[1:0], 3'b000} +: 8];
                endcase
            end
        end
    end

    assign SEG_SELECT_OUT = seg_q;
    assign HEX_OUT        = hex_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-count based reference of scan, commit, PWM, LZS and readback.
module tb_seg7_scan_ctrl;
    localparam int         N     = 4;
    localparam int         RD    = 8;
    localparam int         FRAME = N * RD;
    localparam logic [7:0] BASE  = 8'hD0;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if bus ();
    wire  [7:0]   bus_data;
    logic         tb_drv = 1'b0;
    logic [7:0]   tb_wdat = 8'h00;
    logic [N-1:0] seg;
    logic [7:0]   hex;

    assign bus_data = tb_drv ? tb_wdat : 8'hzz;

    seg7_scan_ctrl #(.BASE_ADDR(BASE), .NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .BUS_DATA       (bus_data),
        .SEG_SELECT_OUT (seg),
        .HEX_OUT        (hex)
    );

    // Reference state: t = clock edges since reset release; counters derive from it arithmetically.
    int         t;
    logic [3:0] sh_dig [8];
    logic [3:0] ac_dig [8];
    logic [7:0] sh_dp, sh_bl, sh_ct, ac_dp, ac_bl, ac_ct;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 8; i++) begin
            sh_dig[i] = 4'h0;
            ac_dig[i] = 4'h0;
        end
        sh_dp = 8'h00; sh_bl = 8'h00; sh_ct = 8'hF1;
        ac_dp = 8'h00; ac_bl = 8'h00; ac_ct = 8'hF1;
    endtask

    task automatic model_write(input logic [7:0] addr, input logic [7:0] wd);
        int o;
        logic [7:0] m;
        o = int'(addr) - int'(BASE);
        m = 8'((1 << N) - 1);
        if (o < 0 || o > 6) return;
        if (o < 4) begin
            if (2 * o < N)     sh_dig[2 * o]     = wd[3:0];
            if (2 * o + 1 < N) sh_dig[2 * o + 1] = wd[7:4];
        end else if (o == 4) sh_dp = wd & m;
        else if (o == 5)     sh_bl = wd & m;
        else                 sh_ct = wd;
    endtask

    function automatic logic [7:0] exp_read(input logic [7:0] addr);
        int o;
        o = int'(addr) - int'(BASE);
        case (o)
            0, 1, 2, 3: return {sh_dig[2 * o + 1], sh_dig[2 * o]};
            4:          return sh_dp;
            5:          return sh_bl;
            6:          return sh_ct;
            default:    return {1'(((t / FRAME) % 2)), 4'b0000, 3'((t / RD) % N)};
        endcase
    endfunction

    task automatic exp_out(output logic [N-1:0] s, output logic [7:0] h);
        int  slot, idx, pwm;
        bit  sup, dp;
        slot = t % RD;
        idx  = (t / RD) % N;
        pwm  = t % 16;
        sup  = ac_ct[1] && idx != 0;
        for (int j = idx; j < N; j++) if (ac_dig[j] != 4'h0) sup = 1'b0;
        dp = ac_dp[idx];
        s  = '1;
        h  = 8'hFF;
        if (ac_ct[0] && slot != 0 && pwm <= int'(ac_ct[7:4]) && !ac_bl[idx] && (!sup || dp)) begin
            s[idx] = 1'b0;
            h = {~dp, sup ? 7'h7F : GLYPH[ac_dig[idx]]};
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // One clock: drive at negedge, optional readback check, model the edge, check pins after it.
    task automatic tick(input bit we, input logic [7:0] addr, input logic [7:0] wd, input bit rd);
        logic [N-1:0] es;
        logic [7:0]   eh;
        @(negedge clk);
        bus.BUS_WE = we; bus.BUS_ADDR = addr; tb_drv = we; tb_wdat = wd;
        if (rd) begin
            #1;
            chk8("readback", bus_data, exp_read(addr));
        end
        @(posedge clk);
        exp_out(es, eh);
        if ((t + 1) % FRAME == 0) begin
            for (int i = 0; i < 8; i++) ac_dig[i] = sh_dig[i];
            ac_dp = sh_dp; ac_bl = sh_bl; ac_ct = sh_ct;
        end
        if (we) model_write(addr, wd);
        t++;
        #1;
        chk8("anodes", 8'(seg), 8'(es));
        chk8("hex", hex, eh);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wr(input int o, input logic [7:0] d);
        tick(1'b1, 8'(int'(BASE) + o), d, 1'b0);
    endtask

    task automatic rd(input int o);
        tick(1'b0, 8'(int'(BASE) + o), 8'h00, 1'b1);
    endtask

    initial begin
        bus.BUS_WE = 1'b0;
        bus.BUS_ADDR = 8'h00;
        #1 reset_n = 1'b0;
        #2;
        chk8("reset_anodes", 8'(seg), 8'(4'hF));
        chk8("reset_hex", hex, 8'hFF);
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 8; k++) rd(k);

        // Basic scan of 4321 after the next commit.
        wr(0, 8'h34);
        wr(1, 8'h12);
        idle(2 * FRAME + 3);

        // Mid-frame write: immediate readback, display waits for the wrap; status across frame.
        while (t % FRAME != 10) idle(1);
        wr(0, 8'($urandom));
        rd(0);
        for (int i = 0; i < FRAME + 4; i++) rd(7);

        // Write on the commit edge itself.
        while ((t + 1) % FRAME != 0) idle(1);
        wr(1, 8'($urandom));
        idle(2 * FRAME);

        // Leading-zero suppression with DP on a suppressed digit.
        wr(0, 8'h05); wr(1, 8'h00); wr(4, 8'h04); wr(6, 8'hF3);
        idle(2 * FRAME);
        for (int it = 0; it < 4; it++) begin
            logic [7:0] b0, b1;
            b0 = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            b1 = ($urandom_range(0, 1) == 0) ? 8'h00 : {4'h0, 4'($urandom)};
            wr(0, b0); wr(1, b1); wr(4, 8'($urandom)); wr(6, 8'hF3);
            idle(2 * FRAME);
        end

        // Brightness: fixed 3, then random levels.
        wr(4, 8'h00); wr(6, 8'h31);
        idle(2 * FRAME);
        for (int it = 0; it < 3; it++) begin
            wr(6, {4'($urandom), 4'b0001});
            idle(2 * FRAME);
        end

        // Blank mask, then disable while the scan keeps running.
        wr(0, 8'h87); wr(1, 8'h9A); wr(5, 8'h0A); wr(6, 8'hF1);
        idle(2 * FRAME);
        wr(6, 8'hF0);
        for (int i = 0; i < 2 * FRAME; i++) rd(7);

        // Random traffic, including the read-only slot and out-of-window neighbours.
        for (int it = 0; it < 40; it++) begin
            int o;
            o = $urandom_range(0, 9) - 1;
            tick(1'b1, 8'(int'(BASE) + o), 8'($urandom), 1'b0);
            if ($urandom_range(0, 2) == 0) rd($urandom_range(0, 7));
            idle($urandom_range(0, 12));
        end
        wr(5, 8'h00); wr(6, 8'hF1);
        idle(FRAME + 2);

        // Asynchronous reset in the middle of a slot.
        for (int k = 0; k < 7; k++) wr(k, 8'($urandom));
        idle(FRAME);
        while (t % RD != 3) idle(1);
        #2 reset_n = 1'b0;
        #1;
        chk8("midreset_anodes", 8'(seg), 8'(4'hF));
        chk8("midreset_hex", hex, 8'hFF);
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 8; k++) rd(k);
        idle(FRAME + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
